ascon_stream_ctrl: RTL

ASCON_STREAM_CTRL -- requirements
Module: ascon_stream_ctrl

---
 rtl/ascon_stream_ctrl_if.sv | 30 +++
 rtl/ascon_stream_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_stream_ctrl_if.sv
`default_nettype none
// ascon_stream_ctrl_if: control strobes, data block and status/results exchanged
// between the stream controller (master) and the Ascon core (slave).
interface ascon_stream_ctrl_if;
  logic         init_o;
  logic         associate_data_o;
  logic         finalisation_o;
  logic         data_valid_o;
  logic [63:0]  data_o;
  logic         end_initialisation_i;
  logic         end_associate_i;
  logic         cipher_valid_i;
  logic         end_cipher_i;
  logic         end_tag_i;
  logic [63:0]  cipher_i;
  logic [127:0] tag_i;

  modport master (
    output init_o, associate_data_o, finalisation_o, data_valid_o, data_o,
    input  end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i,
           end_tag_i, cipher_i, tag_i
  );

  modport slave (
    input  init_o, associate_data_o, finalisation_o, data_valid_o, data_o,
    output end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i,
           end_tag_i, cipher_i, tag_i
  );
endinterface
`default_nettype wire

// File: rtl/ascon_stream_ctrl.sv
`default_nettype none
// ascon_stream_ctrl: feeds latched AD and plaintext blocks through an Ascon core,
// collects ciphertext and tag, with per-state watchdog and synchronous abort.
module ascon_stream_ctrl #(
  parameter int N_PT    = 23,
  parameter int N_AD    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [N_PT*64-1:0]   plain_text_i,
  input  logic [N_AD*64-1:0]   da_i,
  ascon_stream_ctrl_if.master  core,
  output logic [N_PT*64-1:0]   cipher_o,
  output logic [127:0]         tag_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int MAX_N = (N_PT > N_AD) ? N_PT : N_AD;
  localparam int CNT_W = $clog2(MAX_N) + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PT_LAST  = CNT_W'(N_PT - 1);
  localparam logic [CNT_W-1:0] AD_LAST  = CNT_W'(N_AD - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_WAIT_INIT = 4'd2,
    S_AD_SEND   = 4'd3,
    S_AD_WAIT   = 4'd4,
    S_PT_SEND   = 4'd5,
    S_PT_WAIT   = 4'd6,
    S_FIN_SEND  = 4'd7,
    S_FIN_WAIT  = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t                  state, state_nxt;
  logic [N_PT-1:0][63:0]   pt_q;
  logic [N_AD-1:0][63:0]   ad_q;
  logic [N_PT-1:0][63:0]   cipher_q;
  logic [127:0]            tag_q;
  logic [CNT_W-1:0]        ad_idx, ad_idx_nxt;
  logic [CNT_W-1:0]        pt_idx, pt_idx_nxt;
  logic [CNT_W-1:0]        pt_sel;
  logic [WD_W-1:0]         wd;
  logic                    err_q;
  logic                    wd_state;
  logic                    wd_expired;
  logic                    cipher_we;
  logic                    tag_we;
  logic                    dv;
  logic [63:0]             ad_blk;
  logic [63:0]             pt_blk;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= S_IDLE;
      pt_q     <= '0;
      ad_q     <= '0;
      cipher_q <= '0;
      tag_q    <= '0;
      ad_idx   <= '0;
      pt_idx   <= '0;
      wd       <= '0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ad_idx <= ad_idx_nxt;
      pt_idx <= pt_idx_nxt;
      err_q  <= wd_expired;
      if ((state_nxt != state) || !wd_state) begin
        wd <= '0;
      end else begin
        wd <= wd + WD_W'(1);
      end
      // Inputs are captured only on the accepted start so later changes cannot disturb the run.
      if ((state == S_IDLE) && (state_nxt == S_INIT)) begin
        pt_q     <= plain_text_i;
        ad_q     <= da_i;
        cipher_q <= '0;
      end
      if (cipher_we) begin
        for (int b = 0; b < N_PT; b++) begin
          if (pt_sel == CNT_W'(b)) begin
            cipher_q[N_PT-1-b] <= core.cipher_i;
          end
        end
      end
      if (tag_we) begin
        tag_q <= core.tag_i;
      end
    end
  end

  assign wd_state = (state == S_WAIT_INIT) || (state == S_AD_WAIT) ||
                    (state == S_PT_SEND)   || (state == S_PT_WAIT) ||
                    (state == S_FIN_SEND)  || (state == S_FIN_WAIT);

  always_comb begin
    state_nxt  = state;
    ad_idx_nxt = ad_idx;
    pt_idx_nxt = pt_idx;
    cipher_we  = 1'b0;
    tag_we     = 1'b0;
    wd_expired = 1'b0;
    case (state)
      S_IDLE:      if (start_i) state_nxt = S_INIT;
      S_INIT:      state_nxt = S_WAIT_INIT;
      S_WAIT_INIT: begin
        if (core.end_initialisation_i) begin
          state_nxt  = S_AD_SEND;
          ad_idx_nxt = '0;
        end
      end
      S_AD_SEND:   state_nxt = S_AD_WAIT;
      S_AD_WAIT: begin
        if (core.end_associate_i) begin
          if (ad_idx < AD_LAST) begin
            state_nxt  = S_AD_SEND;
            ad_idx_nxt = ad_idx + CNT_W'(1);
          end else begin
            state_nxt  = (N_PT > 1) ? S_PT_SEND : S_FIN_SEND;
            pt_idx_nxt = '0;
          end
        end
      end
      S_PT_SEND: begin
        if (core.cipher_valid_i) begin
          cipher_we = 1'b1;
          state_nxt = S_PT_WAIT;
        end
      end
      S_PT_WAIT: begin
        if (core.end_cipher_i) begin
          // The last plaintext block always goes out with finalisation.
          if ((pt_idx + CNT_W'(1)) < PT_LAST) begin
            state_nxt  = S_PT_SEND;
            pt_idx_nxt = pt_idx + CNT_W'(1);
          end else begin
            state_nxt = S_FIN_SEND;
          end
        end
      end
      S_FIN_SEND: begin
        if (core.cipher_valid_i) begin
          cipher_we = 1'b1;
          state_nxt = S_FIN_WAIT;
        end
      end
      S_FIN_WAIT: begin
        if (core.end_tag_i) begin
          tag_we    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase

    if (wd_state && (state_nxt == state) && (wd == WD_LIMIT)) begin
      wd_expired = 1'b1;
      state_nxt  = S_IDLE;
    end

    if (abort_i) begin
      state_nxt  = S_IDLE;
      wd_expired = 1'b0;
      cipher_we  = 1'b0;
      tag_we     = 1'b0;
    end
  end

  assign pt_sel = (state == S_FIN_SEND) ? PT_LAST : pt_idx;

  always_comb begin
    ad_blk = '0;
    for (int b = 0; b < N_AD; b++) begin
      if (ad_idx == CNT_W'(b)) ad_blk = ad_q[N_AD-1-b];
    end
    pt_blk = '0;
    for (int b = 0; b < N_PT; b++) begin
      if (pt_sel == CNT_W'(b)) pt_blk = pt_q[N_PT-1-b];
    end
  end

  assign dv                    = (state == S_AD_SEND) || (state == S_PT_SEND) || (state == S_FIN_SEND);
  assign core.init_o           = (state == S_INIT);
  assign core.associate_data_o = (state == S_AD_SEND);
  assign core.finalisation_o   = (state == S_FIN_SEND);
  assign core.data_valid_o     = dv;
  assign core.data_o           = !dv ? 64'd0 : ((state == S_AD_SEND) ? ad_blk : pt_blk);

  assign cipher_o = cipher_q;
  assign tag_o    = tag_q;
  assign busy_o   = (state != S_IDLE);
  assign done_o   = (state == S_DONE) && !abort_i;
  assign error_o  = err_q;

endmodule
`default_nettype wire
